spi_req_arbiter: RTL and testbench

- Shares one SPI master interface (command: wr/addr/din; status: done/err/dout) between NREQ requesters, e.g. a register-programming sequencer and a host bus bridge.
- Round-robin arbitration between requesters.
- Rejects out-of-range addresses locally, without issuing them to the master.
- Issues one transaction at a time with a single-cycle start pulse.
- Enforces a completion timeout and returns a per-requester response pulse.

---
 rtl/spi_req_arbiter.sv | 170 +++++++++++++++++
 tb/tb_spi_req_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_req_arbiter.sv
// Round-robin sharing of one SPI master between NREQ requesters, with local address rejection and a WAIT timeout.
// A request seen in IDLE is granted the next cycle. A requester holds req until its one-cycle rsp_valid pulse.
module spi_req_arbiter #(
  parameter int NREQ     = 2,
  parameter int MAX_ADDR = 32,
  parameter int TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_wr,
  input  logic [NREQ*8-1:0] req_addr,
  input  logic [NREQ*8-1:0] req_din,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic              rsp_err,
  output logic [7:0]        rsp_dout,
  output logic              busy,
  output logic              m_start,
  output logic              m_wr,
  output logic [7:0]        m_addr,
  output logic [7:0]        m_din,
  output logic              m_abort,
  input  logic              m_done,
  input  logic              m_err,
  input  logic [7:0]        m_dout
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, REJECT} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] ptr;
  logic [IW-1:0] win;
  logic [IW-1:0] win_idx;
  logic          win_found;
  logic [7:0]    sel_addr;
  logic          addr_ok;
  logic [CW-1:0] cnt;
  logic          timeout_hit;
  logic          err_q;
  logic [7:0]    dout_q;

  // First requesting index at or after ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_found && req[(int'(ptr) + k) % NREQ]) begin
        win_found = 1'b1;
        win_idx   = IW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  assign sel_addr    = req_addr[int'(win_idx)*8 +: 8];
  assign addr_ok     = int'(sel_addr) < MAX_ADDR;
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    m_start   = 1'b0;
    m_abort   = 1'b0;
    rsp_valid = '0;
    rsp_err   = 1'b0;
    rsp_dout  = '0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt = addr_ok ? ISSUE : REJECT;
        end
      end
      ISSUE: begin
        m_start   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        // Completion beats the timeout when both land in the same cycle.
        if (m_done) begin
          state_nxt = RESP;
        end else if (timeout_hit) begin
          m_abort   = 1'b1;
          state_nxt = RESP;
        end
      end
      REJECT: begin
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = gnt;
        rsp_err   = err_q;
        rsp_dout  = dout_q;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= '0;
      win    <= '0;
      gnt    <= '0;
      m_wr   <= 1'b0;
      m_addr <= '0;
      m_din  <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            win    <= win_idx;
            gnt    <= ONE << win_idx;
            m_wr   <= req_wr[win_idx];
            m_addr <= sel_addr;
            m_din  <= req_din[int'(win_idx)*8 +: 8];
            err_q  <= 1'b0;
            dout_q <= '0;
          end
        end
        ISSUE: begin
          cnt <= '0;
        end
        WAIT: begin
          if (m_done) begin
            err_q  <= m_err;
            dout_q <= m_wr ? 8'h00 : m_dout;
          end else if (timeout_hit) begin
            err_q  <= 1'b1;
            dout_q <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        REJECT: begin
          err_q  <= 1'b1;
          dout_q <= '0;
        end
        RESP: begin
          ptr    <= (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
          gnt    <= '0;
          m_wr   <= 1'b0;
          m_addr <= '0;
          m_din  <= '0;
          err_q  <= 1'b0;
          dout_q <= '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Bench for spi_req_arbiter: vector table, hand-written corner sequences and random traffic
// checked every cycle against a transaction-timeline model.
module tb_spi_req_arbiter;
  localparam int NREQ     = 2;
  localparam int MAX_ADDR = 32;
  localparam int TIMEOUT  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_wr;
  logic [NREQ*8-1:0] req_addr;
  logic [NREQ*8-1:0] req_din;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rsp_valid;
  logic              rsp_err;
  logic [7:0]        rsp_dout;
  logic              busy;
  logic              m_start;
  logic              m_wr;
  logic [7:0]        m_addr;
  logic [7:0]        m_din;
  logic              m_abort;
  logic              m_done;
  logic              m_err;
  logic [7:0]        m_dout;

  always #5 clk = ~clk;

  spi_req_arbiter #(.NREQ(NREQ), .MAX_ADDR(MAX_ADDR), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr), .req_din(req_din),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_dout(rsp_dout), .busy(busy),
    .m_start(m_start), .m_wr(m_wr), .m_addr(m_addr), .m_din(m_din), .m_abort(m_abort),
    .m_done(m_done), .m_err(m_err), .m_dout(m_dout)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Transaction timeline: t0 is the IDLE cycle in which the request is seen.
  bit         plan_act;
  int         t0, pw, pL, ptr_m;
  bit         prej, perr, pmerr, pwr;
  logic [7:0] pdout, pmdout, paddr, pdin;
  int         next_lat;
  bit         next_merr;
  logic [7:0] next_mdout;
  bit         noise_en;

  int              rsp_w_exp;
  bit              rsp_seen;
  int              rsp_cyc;
  logic [NREQ-1:0] rsp_vec;
  logic            rsp_e;
  logic [7:0]      rsp_d;
  int              n_start, n_abort, abort_cyc;
  int              watch_cyc;
  logic [NREQ-1:0] watch_gnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic cycle();
    int rel, r;
    logic [NREQ-1:0] e_gnt, e_rv;
    logic e_err, e_busy, e_start, e_abort, e_wr;
    logic [7:0] e_dout, e_addr, e_din;
    bit cmd_chk, in_wait;
    rel = 0;
    r = 0;
    if (!rst && !plan_act && req != '0) begin
      plan_act = 1'b1;
      t0 = cyc;
      pw = -1;
      for (int k = 0; k < NREQ; k++)
        if (pw < 0 && req[(ptr_m + k) % NREQ]) pw = (ptr_m + k) % NREQ;
      pwr = req_wr[pw];
      paddr = req_addr[8*pw +: 8];
      pdin = req_din[8*pw +: 8];
      prej = int'(paddr) >= MAX_ADDR;
      pL = next_lat;
      pmerr = next_merr;
      pmdout = next_mdout;
      if (prej || pL >= TIMEOUT) begin
        perr = 1'b1;
        pdout = 8'h00;
      end else begin
        perr = pmerr;
        pdout = pwr ? 8'h00 : pmdout;
      end
    end
    if (plan_act) begin
      rel = cyc - t0;
      r = prej ? 2 : 3 + ((pL < TIMEOUT - 1) ? pL : TIMEOUT - 1);
    end
    in_wait = plan_act && !prej && rel >= 2 && rel < r;
    if (in_wait && pL < TIMEOUT && rel == 2 + pL) begin
      m_done = 1'b1;
      m_err = pmerr;
      m_dout = pmdout;
    end else begin
      m_done = (!in_wait && noise_en) ? 1'($urandom_range(0, 1)) : 1'b0;
      m_err = 1'($urandom_range(0, 1));
      m_dout = 8'($urandom_range(0, 255));
    end
    e_gnt = '0; e_rv = '0; e_err = 1'b0; e_busy = 1'b0; e_start = 1'b0; e_abort = 1'b0;
    e_wr = 1'b0; e_dout = '0; e_addr = '0; e_din = '0; cmd_chk = 1'b1;
    rsp_w_exp = -1;
    if (plan_act && rel >= 1) begin
      e_gnt = NREQ'(1 << pw);
      e_busy = 1'b1;
      if (prej) cmd_chk = 1'b0;
      else begin
        e_wr = pwr;
        e_addr = paddr;
        e_din = pdin;
      end
      e_start = !prej && rel == 1;
      e_abort = !prej && pL >= TIMEOUT && rel == TIMEOUT + 1;
      if (rel == r) begin
        e_rv = e_gnt;
        e_err = perr;
        e_dout = pdout;
        rsp_w_exp = pw;
      end
    end
    @(negedge clk);
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
    chk("rsp_err", 32'(rsp_err), 32'(e_err));
    chk("rsp_dout", 32'(rsp_dout), 32'(e_dout));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("m_start", 32'(m_start), 32'(e_start));
    chk("m_abort", 32'(m_abort), 32'(e_abort));
    if (cmd_chk) begin
      chk("m_wr", 32'(m_wr), 32'(e_wr));
      chk("m_addr", 32'(m_addr), 32'(e_addr));
      chk("m_din", 32'(m_din), 32'(e_din));
    end
    if (rsp_valid != '0) begin
      rsp_seen = 1'b1;
      rsp_cyc = cyc;
      rsp_vec = rsp_valid;
      rsp_e = rsp_err;
      rsp_d = rsp_dout;
    end
    if (m_start) n_start++;
    if (m_abort) begin
      n_abort++;
      abort_cyc = cyc;
    end
    if (cyc == watch_cyc) watch_gnt = gnt;
    if (rst) begin
      plan_act = 1'b0;
      ptr_m = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (plan_act && cyc - t0 > r) begin
      plan_act = 1'b0;
      ptr_m = (pw + 1) % NREQ;
    end
  endtask

  task automatic new_cmd(input int i);
    req_wr[i] = 1'($urandom_range(0, 1));
    req_addr[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, 31));
    req_din[8*i +: 8] = 8'($urandom_range(0, 255));
  endtask

  typedef struct {
    logic [NREQ-1:0] req;
    bit              wr;
    logic [7:0]      addr;
    logic [7:0]      din;
    int              lat;
    bit              merr;
    logic [7:0]      mdout;
    logic [NREQ-1:0] e_gnt;
    int              e_rsp_at;
    bit              e_err;
    logic [7:0]      e_dout;
    int              e_starts;
    int              e_aborts;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int t_req, s0, a0, nr;
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] order [4];
    logic [NREQ-1:0] exp_order [4];

    vecs[0] = '{2'b01, 1'b1, 8'h05, 8'hA5, 5, 1'b0, 8'h77, 2'b01, 8, 1'b0, 8'h00, 1, 0};
    vecs[1] = '{2'b10, 1'b0, 8'h1F, 8'h00, 0, 1'b0, 8'h3C, 2'b10, 3, 1'b0, 8'h3C, 1, 0};
    vecs[2] = '{2'b01, 1'b0, 8'h20, 8'h11, 0, 1'b0, 8'h00, 2'b01, 2, 1'b1, 8'h00, 0, 0};
    vecs[3] = '{2'b10, 1'b1, 8'h10, 8'h99, 2, 1'b1, 8'h00, 2'b10, 5, 1'b1, 8'h00, 1, 0};
    vecs[4] = '{2'b01, 1'b0, 8'h1F, 8'h00, 9, 1'b0, 8'h5A, 2'b01, 10, 1'b1, 8'h00, 1, 1};
    vecs[5] = '{2'b10, 1'b0, 8'h00, 8'h00, 7, 1'b0, 8'hC3, 2'b10, 10, 1'b0, 8'hC3, 1, 0};
    vecs[6] = '{2'b01, 1'b1, 8'h03, 8'h42, 7, 1'b1, 8'h00, 2'b01, 10, 1'b1, 8'h00, 1, 0};
    vecs[7] = '{2'b01, 1'b0, 8'h1F, 8'h00, 1, 1'b0, 8'h81, 2'b01, 4, 1'b0, 8'h81, 1, 0};
    vecs[8] = '{2'b10, 1'b0, 8'hFF, 8'h00, 0, 1'b0, 8'h00, 2'b10, 2, 1'b1, 8'h00, 0, 0};
    exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};

    rst = 1'b1; req = '0; req_wr = '0; req_addr = '0; req_din = '0;
    m_done = 1'b0; m_err = 1'b0; m_dout = '0;
    plan_act = 1'b0; ptr_m = 0; noise_en = 1'b0;
    next_lat = 0; next_merr = 1'b0; next_mdout = '0;
    rsp_seen = 1'b0; rsp_cyc = 0; rsp_vec = '0; rsp_e = 1'b0; rsp_d = '0;
    n_start = 0; n_abort = 0; abort_cyc = 0; watch_cyc = -1; watch_gnt = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();
    cycle();

    foreach (vecs[i]) begin
      req = vecs[i].req;
      req_wr = {NREQ{vecs[i].wr}};
      req_addr = {NREQ{vecs[i].addr}};
      req_din = {NREQ{vecs[i].din}};
      next_lat = vecs[i].lat;
      next_merr = vecs[i].merr;
      next_mdout = vecs[i].mdout;
      t_req = cyc; watch_cyc = cyc + 1; rsp_seen = 1'b0; s0 = n_start; a0 = n_abort;
      for (int k = 0; k < 20 && !rsp_seen; k++) cycle();
      req = '0;
      cycle();
      chk($sformatf("vec%0d_rsp_seen", i), 32'(rsp_seen), 32'd1);
      chk($sformatf("vec%0d_rsp_at", i), 32'(rsp_cyc - t_req), 32'(vecs[i].e_rsp_at));
      chk($sformatf("vec%0d_rsp_vec", i), 32'(rsp_vec), 32'(vecs[i].e_gnt));
      chk($sformatf("vec%0d_err", i), 32'(rsp_e), 32'(vecs[i].e_err));
      chk($sformatf("vec%0d_dout", i), 32'(rsp_d), 32'(vecs[i].e_dout));
      chk($sformatf("vec%0d_gnt", i), 32'(watch_gnt), 32'(vecs[i].e_gnt));
      chk($sformatf("vec%0d_starts", i), 32'(n_start - s0), 32'(vecs[i].e_starts));
      chk($sformatf("vec%0d_aborts", i), 32'(n_abort - a0), 32'(vecs[i].e_aborts));
      if (vecs[i].e_aborts > 0) chk($sformatf("vec%0d_abort_at", i), 32'(abort_cyc - t_req), 32'd9);
    end

    // Contention: both requesters stay up and re-request after every response.
    req = 2'b11; req_wr = '0; req_addr = {8'h03, 8'h02}; req_din = '0;
    next_lat = 1; next_merr = 1'b0; next_mdout = 8'h5C;
    nr = 0; s0 = n_start;
    for (int k = 0; k < 80 && nr < 4; k++) begin
      rsp_seen = 1'b0;
      cycle();
      if (rsp_seen) begin
        order[nr] = rsp_vec;
        nr++;
      end
    end
    req = '0;
    cycle();
    chk("rr_count", 32'(nr), 32'd4);
    for (int k = 0; k < 4; k++) chk($sformatf("rr_order%0d", k), 32'(order[k]), 32'(exp_order[k]));
    chk("rr_starts", 32'(n_start - s0), 32'd4);

    // Reset in WAIT with ptr pointing at requester 1.
    req = 2'b01; req_addr = {8'h05, 8'h04}; next_lat = 0; rsp_seen = 1'b0;
    for (int k = 0; k < 20 && !rsp_seen; k++) cycle();
    req = '0;
    cycle();
    req = 2'b10; next_lat = 9;
    repeat (5) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0; req = '0; rsp_seen = 1'b0;
    repeat (3) cycle();
    chk("rst_no_rsp", 32'(rsp_seen), 32'd0);
    req = 2'b11; next_lat = 0; watch_cyc = cyc + 1;
    for (int k = 0; k < 20 && !rsp_seen; k++) cycle();
    req = '0;
    cycle();
    chk("rst_gnt", 32'(watch_gnt), 32'b01);
    chk("rst_rsp_vec", 32'(rsp_vec), 32'b01);

    // Random traffic with master noise outside WAIT.
    noise_en = 1'b1;
    pend = '0;
    for (int n = 0; n < 2500; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          new_cmd(i);
        end else if (pend[i] && plan_act && pw == i && $urandom_range(0, 3) == 0) begin
          new_cmd(i);
        end
      end
      req = pend;
      next_lat = $urandom_range(0, 9);
      next_merr = ($urandom_range(0, 3) == 0);
      next_mdout = next_merr ? 8'h00 : 8'($urandom_range(0, 255));
      cycle();
      if (rsp_w_exp >= 0) begin
        if ($urandom_range(0, 3) == 0) new_cmd(rsp_w_exp);
        else pend[rsp_w_exp] = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
